// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement sequencer: enables one oscillator, waits a settle time,
// counts synchronized rising edges over a programmable window, then holds the result for the host.
module ro_meas_ctrl #(
  parameter int N_OSC         = 4,
  parameter int SEL_W         = 2,
  parameter int WIN_W         = 16,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W-1:0] sel,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ack,
  input  logic [N_OSC-1:0] ro_i,
  output logic [N_OSC-1:0] ro_en,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             sat,
  output logic             err
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (WIN_W > SW) ? WIN_W : SW;
  localparam logic [SEL_W:0] N_OSC_V = (SEL_W+1)'(N_OSC);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [SEL_W-1:0] sel_q;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] count_q;
  logic             sat_q, err_q;
  logic             sync1, sync2, hist;
  logic             accept, bad_sel, tmr_tc, rise, ro_mux;
  logic [N_OSC-1:0] sel_oh;

  assign bad_sel = ({1'b0, sel} >= N_OSC_V);
  assign tmr_tc  = (tmr_q == '0);
  assign rise    = sync2 & ~hist;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Single down-counter times both the settle phase and the measurement window.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (bad_sel) begin
            state_d = HOLD;
          end else begin
            state_d = SETTLE;
            tmr_d   = TW'(SETTLE_CYCLES - 1);
          end
        end
      end
      SETTLE: begin
        if (tmr_tc) begin
          if (win_q == '0) begin
            state_d = HOLD;
          end else begin
            state_d = MEASURE;
            tmr_d   = TW'(win_q) - TW'(1);
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      MEASURE: begin
        if (tmr_tc) state_d = HOLD;
        else        tmr_d   = tmr_q - TW'(1);
      end
      HOLD: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < N_OSC; i++) sel_oh[i] = (sel_q == SEL_W'(i));
  end

  // Decoded from the state register so reset drops the enables without a clock edge.
  assign ro_en  = (state_q == SETTLE || state_q == MEASURE) ? sel_oh : '0;
  assign ro_mux = |(ro_i & sel_oh);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      tmr_q   <= '0;
      sel_q   <= '0;
      win_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      hist    <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      sync1 <= ro_mux;
      sync2 <= sync1;
      hist  <= sync2;
      if (accept) begin
        sel_q   <= sel;
        win_q   <= win_len;
        count_q <= '0;
        sat_q   <= 1'b0;
        err_q   <= bad_sel;
      end else if (state_q == MEASURE && rise) begin
        if (count_q == '1) sat_q <= 1'b1;
        else               count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign busy  = (state_q != IDLE);
  assign valid = (state_q == HOLD);
  assign count = count_q;
  assign sat   = sat_q;
  assign err   = err_q;

endmodule

// File: doc/ro_meas_ctrl.md
Name: ro_meas_ctrl

Overview:
Measurement sequencer for on-die ring oscillators built from inverter standard cells. Used for process and speed monitoring. It enables one selected oscillator, waits a settle time, then counts the oscillator's rising edges over a programmable window of ck cycles. The result is presented to a host through a valid/ack handshake. It sits between a host register interface and a bank of N_OSC ring oscillators.

Parameters:
N_OSC, 4, number of ring oscillators controlled
SEL_W, 2, width of oscillator select; 2**SEL_W >= N_OSC
WIN_W, 16, width of window-length field
CNT_W, 16, width of edge counter/result
SETTLE_CYCLES, 8, ck cycles between oscillator enable and start of counting (>=3)

Ports:
ck  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request a measurement; sampled only in IDLE
sel  input  SEL_W  oscillator index; latched with start
win_len  input  WIN_W  measurement window in ck cycles; latched with start
ack  input  1  host acknowledges result; sampled only in HOLD
ro_i  input  N_OSC  raw oscillator outputs, asynchronous to ck
ro_en  output  N_OSC  one-hot oscillator enable
busy  output  1  high in any state other than IDLE
valid  output  1  result available (HOLD state)
count  output  CNT_W  rising edges counted in window
sat  output  1  counter saturated during window
err  output  1  sel >= N_OSC on accepted start

Behaviour:
- Reset (asynchronous, while rst=1): state=IDLE. ro_en, busy, valid, count, sat and err are all 0. Synchronizer flops and internal counters are cleared.
- States: IDLE, SETTLE, MEASURE, HOLD. All registers update on the rising edge of ck.
- IDLE + start=1 at edge t0:
  - Latch sel and win_len.
  - Clear count, sat and err.
  - If sel >= N_OSC: set err=1 and go to HOLD (no enable; count=0).
  - Otherwise go to SETTLE.
- SETTLE:
  - ro_en[sel_latched]=1; all other bits 0.
  - Lasts exactly SETTLE_CYCLES cycles.
  - The synchronizer runs, but edges are not counted.
  - At exit: if win_len_latched=0, go to HOLD with count=0; otherwise go to MEASURE.
- MEASURE:
  - ro_en stays asserted.
  - Lasts exactly win_len_latched cycles.
  - Each cycle in which a rising edge of the synchronized selected oscillator is detected increments count.
  - count saturates at 2**CNT_W-1; sat is set and sticky until the next accepted start.
  - An edge detected in the final MEASURE cycle is counted.
- Timing: valid rises after edge t0 + SETTLE_CYCLES + win_len (non-error case).
- HOLD:
  - valid=1, busy=1, ro_en=0.
  - count, sat and err are stable.
  - On ack=1, go to IDLE at that edge; valid falls and count/sat/err retain their values.
  - ack outside HOLD is ignored.
- Synchronizer:
  - The selected ro_i bit is muxed, passed through 2 flops, then 1 history flop.
  - edge = sync & ~hist.
  - The mux select is the latched sel only, so it is stable through SETTLE/MEASURE.
  - Requirement: oscillator frequency < f_ck/2 for exact counts. Faster oscillators alias; this is not detected.
- start while busy=1 is ignored (no queuing). start and ack high together in HOLD: ack is honoured and start is ignored that cycle.
- Changing sel or win_len after acceptance has no effect.
- rst asserted mid-measurement aborts immediately: ro_en drops asynchronously and the result is lost.

Test Plan:
- Reset/idle: assert rst mid-MEASURE with ro_en=0001 -> ro_en, busy, valid and count go to 0 immediately, without waiting for a ck edge; after release, state is IDLE.
- Nominal count:
  - Stimulus: sel=2, win_len=100, ro_i[2] toggling at f_ck/8 (period 8 ck).
  - Required: ro_en=0100 during SETTLE+MEASURE.
  - Required: valid rises 108 cycles after start.
  - Required: count = 12 or 13 (phase-dependent, ±1 allowed), sat=0, err=0.
  - Required: ack returns to IDLE.
- Zero window: sel=1, win_len=0 -> SETTLE 8 cycles, then HOLD with count=0, sat=0; ro_en=0010 only during SETTLE.
- Bad select: sel=3 with N_OSC=3 -> next cycle valid=1, err=1, count=0; ro_en stays 0 throughout.
- Saturation:
  - Stimulus: CNT_W=4, win_len=200, oscillator at f_ck/4.
  - Required: count=15, sat=1.
  - Required: the next measurement with a slow oscillator clears sat.
- Handshake corners:
  - start while busy is ignored (count unchanged, no restart).
  - start and ack high together in HOLD -> IDLE, no new measurement.
  - Changing sel mid-MEASURE does not change ro_en.
